// File: rtl/sa_aw_arbiter.sv
// Per-slave write-address arbiter: shares one slave AW channel between
// MST_AMT dispatchers using round-robin, registers the granted AW into a
// single output stage, reports each grant to the W/B ordering logic and
// throttles new grants against the number of outstanding writes.
module sa_aw_arbiter #(
    parameter int MST_AMT           = 2,
    parameter int OUTSTANDING_AMT   = 8,
    parameter int OUTST_CTN_W       = $clog2(OUTSTANDING_AMT) + 1,
    parameter int TRANS_MST_ID_W    = 5,
    parameter int ADDR_WIDTH        = 32,
    parameter int TRANS_BURST_W     = 2,
    parameter int TRANS_DATA_LEN_W  = 3,
    parameter int TRANS_DATA_SIZE_W = 3,
    // A single master still needs a one-bit index so the ports stay legal.
    parameter int MST_ID_W          = (MST_AMT > 1) ? $clog2(MST_AMT) : 1,
    parameter int AW_INFO_W         = TRANS_MST_ID_W + ADDR_WIDTH + TRANS_BURST_W
                                      + TRANS_DATA_LEN_W + TRANS_DATA_SIZE_W
) (
    input  logic                           ACLK_i,
    input  logic                           ARESET_i,
    input  logic [AW_INFO_W*MST_AMT-1:0]   dsp_AW_info_i,
    input  logic [MST_AMT-1:0]             dsp_AWVALID_i,
    output logic [MST_AMT-1:0]             dsp_AWREADY_o,
    output logic [AW_INFO_W-1:0]           s_AW_info_o,
    output logic                           s_AWVALID_o,
    input  logic                           s_AWREADY_i,
    input  logic                           s_BVALID_i,
    input  logic                           s_BREADY_i,
    output logic [MST_ID_W-1:0]            sa_AW_mst_id_o,
    output logic                           sa_AW_shift_en_o,
    output logic [OUTST_CTN_W-1:0]         sa_outst_ctn_o
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_e;

    stage_e                state;
    logic [MST_ID_W-1:0]   rr_ptr;
    logic [MST_ID_W-1:0]   win;
    logic [MST_ID_W-1:0]   ptr_next;
    logic [AW_INFO_W-1:0]  win_info;
    logic                  stage_free;
    logic                  cnt_ok;
    logic                  grant_en;
    logic                  b_hs;

    // Throttle: the stage accepts a new AW when empty or draining this cycle,
    // and only the registered count gates it (a same-cycle B does not unlock).
    assign stage_free = (state == ST_EMPTY) | s_AWREADY_i;
    assign cnt_ok     = sa_outst_ctn_o < OUTST_CTN_W'(OUTSTANDING_AMT);
    assign grant_en   = ~ARESET_i & stage_free & cnt_ok & (|dsp_AWVALID_i);
    assign b_hs       = s_BVALID_i & s_BREADY_i;

    // Round-robin search: lowest requester at or above the pointer wins,
    // otherwise wrap and take the lowest requester overall.
    always_comb begin
        logic                hi_found;
        logic [MST_ID_W-1:0] hi_win;
        logic [MST_ID_W-1:0] lo_win;
        // NOTE: every variable gets a default before any branch so the
        // combinational block cannot infer a latch.
        hi_found = 1'b0;
        hi_win   = '0;
        lo_win   = '0;
        // Descending scan so the last hit kept is the lowest index.
        for (int m = MST_AMT - 1; m >= 0; m--) begin
            if (dsp_AWVALID_i[m]) begin
                lo_win = MST_ID_W'(m);
                if (MST_ID_W'(m) >= rr_ptr) begin
                    hi_found = 1'b1;
                    hi_win   = MST_ID_W'(m);
                end
            end
        end
        win = hi_found ? hi_win : lo_win;
    end

    // Pointer moves one past the winner, wrapping at the last master.
    always_comb begin
        ptr_next = '0;
        if (MST_AMT > 1 && win != MST_ID_W'(MST_AMT - 1)) begin
            ptr_next = win + MST_ID_W'(1);
        end
    end

    // Select the winning master's payload slice.
    always_comb begin
        win_info = '0;
        for (int m = 0; m < MST_AMT; m++) begin
            if (win == MST_ID_W'(m)) begin
                win_info = dsp_AW_info_i[AW_INFO_W*m +: AW_INFO_W];
            end
        end
    end

    // Same-cycle grant outputs: one-hot accept, winner index and push strobe.
    always_comb begin
        dsp_AWREADY_o    = '0;
        sa_AW_mst_id_o   = '0;
        sa_AW_shift_en_o = grant_en;
        if (grant_en) begin
            sa_AW_mst_id_o = win;
        end
        for (int m = 0; m < MST_AMT; m++) begin
            dsp_AWREADY_o[m] = grant_en && (win == MST_ID_W'(m));
        end
    end

    // Output stage FSM: load on grant, hold until the slave accepts.
    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            // NOTE: non-blocking assignments for all registered state so every
            // flop samples pre-edge values regardless of statement order.
            state       <= ST_EMPTY;
            s_AWVALID_o <= 1'b0;
            s_AW_info_o <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (grant_en) begin
                        state       <= ST_FULL;
                        s_AWVALID_o <= 1'b1;
                        s_AW_info_o <= win_info;
                    end
                end
                ST_FULL: begin
                    if (grant_en) begin
                        // Handshake and new grant together: reload, no bubble.
                        s_AW_info_o <= win_info;
                    end else if (s_AWREADY_i) begin
                        state       <= ST_EMPTY;
                        s_AWVALID_o <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_EMPTY;
                    s_AWVALID_o <= 1'b0;
                end
            endcase
        end
    end

    // Round-robin pointer advances only on a grant.
    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            rr_ptr <= '0;
        end else if (grant_en) begin
            rr_ptr <= ptr_next;
        end
    end

    // Outstanding-write counter: +1 per grant, -1 per B handshake, floor at 0.
    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            sa_outst_ctn_o <= '0;
        end else if (grant_en && !b_hs) begin
            sa_outst_ctn_o <= sa_outst_ctn_o + OUTST_CTN_W'(1);
        end else if (!grant_en && b_hs && sa_outst_ctn_o != '0) begin
            sa_outst_ctn_o <= sa_outst_ctn_o - OUTST_CTN_W'(1);
        end
    end

endmodule

// File: tb/tb_sa_aw_arbiter.sv
// Self-checking bench for sa_aw_arbiter: directed scenarios plus random
// traffic, all compared against a cycle-level behavioural reference model.
module tb_sa_aw_arbiter;

    localparam int MST_AMT         = 2;
    localparam int OUTSTANDING_AMT = 8;
    localparam int CNT_W           = 4;
    localparam int ID_W            = 1;
    localparam int AW_INFO_W       = 45;

    logic                         clk;
    logic                         ARESET_i;
    logic [AW_INFO_W*MST_AMT-1:0] dsp_AW_info_i;
    logic [MST_AMT-1:0]           dsp_AWVALID_i;
    logic [MST_AMT-1:0]           dsp_AWREADY_o;
    logic [AW_INFO_W-1:0]         s_AW_info_o;
    logic                         s_AWVALID_o;
    logic                         s_AWREADY_i;
    logic                         s_BVALID_i;
    logic                         s_BREADY_i;
    logic [ID_W-1:0]              sa_AW_mst_id_o;
    logic                         sa_AW_shift_en_o;
    logic [CNT_W-1:0]             sa_outst_ctn_o;

    sa_aw_arbiter #(
        .MST_AMT         (MST_AMT),
        .OUTSTANDING_AMT (OUTSTANDING_AMT)
    ) dut (
        .ACLK_i           (clk),
        .ARESET_i         (ARESET_i),
        .dsp_AW_info_i    (dsp_AW_info_i),
        .dsp_AWVALID_i    (dsp_AWVALID_i),
        .dsp_AWREADY_o    (dsp_AWREADY_o),
        .s_AW_info_o      (s_AW_info_o),
        .s_AWVALID_o      (s_AWVALID_o),
        .s_AWREADY_i      (s_AWREADY_i),
        .s_BVALID_i       (s_BVALID_i),
        .s_BREADY_i       (s_BREADY_i),
        .sa_AW_mst_id_o   (sa_AW_mst_id_o),
        .sa_AW_shift_en_o (sa_AW_shift_en_o),
        .sa_outst_ctn_o   (sa_outst_ctn_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one slot holding the presented AW, a priority pointer
    // and an integer count of writes still awaiting a B response.
    bit                   m_full;
    logic [AW_INFO_W-1:0] m_info;
    int                   m_ptr;
    int                   m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AW_INFO_W-1:0] rand_info();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[AW_INFO_W-1:0];
    endfunction

    // One clock cycle: drive inputs, compare DUT against model, advance model.
    task automatic step(input bit rst, input bit [MST_AMT-1:0] vld,
                        input bit aw_rdy, input bit bv, input bit br);
        int win;
        bit g;
        bit b;
        logic [MST_AMT-1:0] exp_rdy;
        @(negedge clk);
        ARESET_i      = rst;
        dsp_AWVALID_i = vld;
        s_AWREADY_i   = aw_rdy;
        s_BVALID_i    = bv;
        s_BREADY_i    = br;
        for (int m = 0; m < MST_AMT; m++) begin
            dsp_AW_info_i[m*AW_INFO_W +: AW_INFO_W] = rand_info();
        end
        #1;
        check("awvalid", 64'(s_AWVALID_o), 64'(m_full));
        if (m_full) check("awinfo", 64'(s_AW_info_o), 64'(m_info));
        check("outst", 64'(sa_outst_ctn_o), 64'(m_cnt));

        win = -1;
        for (int k = 0; k < MST_AMT; k++) begin
            int c;
            c = (m_ptr + k) % MST_AMT;
            if (win < 0 && vld[c]) win = c;
        end
        g = !rst && (!m_full || aw_rdy) && (m_cnt < OUTSTANDING_AMT) && (win >= 0);
        exp_rdy = '0;
        if (g) exp_rdy[win] = 1'b1;
        check("awready", 64'(dsp_AWREADY_o), 64'(exp_rdy));
        check("mst_id", 64'(sa_AW_mst_id_o), g ? 64'(win) : 64'd0);
        check("shift_en", 64'(sa_AW_shift_en_o), 64'(g));

        if (rst) begin
            m_full = 1'b0;
            m_info = '0;
            m_ptr  = 0;
            m_cnt  = 0;
        end else begin
            if (g) begin
                m_full = 1'b1;
                m_info = dsp_AW_info_i[win*AW_INFO_W +: AW_INFO_W];
                m_ptr  = (win + 1) % MST_AMT;
            end else if (aw_rdy) begin
                m_full = 1'b0;
            end
            b = bv && br;
            if (g && !b) m_cnt++;
            else if (!g && b && m_cnt > 0) m_cnt--;
        end
        @(posedge clk);
    endtask

    initial begin
        ARESET_i      = 1'b1;
        dsp_AWVALID_i = '0;
        dsp_AW_info_i = '0;
        s_AWREADY_i   = 1'b0;
        s_BVALID_i    = 1'b0;
        s_BREADY_i    = 1'b0;
        m_full = 1'b0;
        m_info = '0;
        m_ptr  = 0;
        m_cnt  = 0;
        repeat (2) @(posedge clk);

        // Reset held with both masters requesting: every output stays 0.
        step(1, 2'b11, 1, 0, 0);
        #1;
        check("rst_info", 64'(s_AW_info_o), 64'd0);
        // Release: master 0 first, then visible on the slave side next cycle.
        step(0, 2'b11, 1, 0, 0);
        // Continuous requests, slave always ready, B every cycle: 1,0,1,0...
        repeat (8) step(0, 2'b11, 1, 1, 1);
        #1;
        check("alt_cnt", 64'(sa_outst_ctn_o), 64'd1);

        // Slave stalls five cycles: payload held, no accepts; then the next
        // master is granted in the same cycle the slave becomes ready.
        repeat (5) step(0, 2'b11, 0, 0, 0);
        step(0, 2'b11, 1, 0, 0);

        // Throttle at OUTSTANDING_AMT with no responses from master 0.
        step(1, 2'b00, 0, 0, 0);
        repeat (10) step(0, 2'b01, 1, 0, 0);
        #1;
        check("cnt_full", 64'(sa_outst_ctn_o), 64'd8);
        step(0, 2'b01, 1, 1, 1);
        #1;
        check("cnt_after_b", 64'(sa_outst_ctn_o), 64'd7);
        step(0, 2'b01, 1, 0, 0);
        #1;
        check("cnt_refill", 64'(sa_outst_ctn_o), 64'd8);

        // Grant and B together at count 3, then drain past zero.
        step(1, 2'b00, 0, 0, 0);
        repeat (3) step(0, 2'b01, 1, 0, 0);
        step(0, 2'b01, 1, 1, 1);
        #1;
        check("cnt_incdec", 64'(sa_outst_ctn_o), 64'd3);
        repeat (5) step(0, 2'b00, 1, 1, 1);
        #1;
        check("cnt_floor", 64'(sa_outst_ctn_o), 64'd0);

        // Reset while an AW is held and five writes are outstanding.
        step(1, 2'b00, 0, 0, 0);
        repeat (5) step(0, 2'b01, 1, 0, 0);
        step(0, 2'b00, 0, 0, 0);
        #1;
        check("pre_rst_valid", 64'(s_AWVALID_o), 64'd1);
        check("pre_rst_cnt", 64'(sa_outst_ctn_o), 64'd5);
        step(1, 2'b11, 0, 0, 0);
        #1;
        check("rst_valid", 64'(s_AWVALID_o), 64'd0);
        check("rst_cnt", 64'(sa_outst_ctn_o), 64'd0);
        // Pointer was 1 before reset; master 0 must win now.
        step(0, 2'b11, 1, 0, 0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(99) == 0),
                 MST_AMT'($urandom),
                 ($urandom_range(3) != 0),
                 ($urandom_range(2) == 0),
                 ($urandom_range(3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
